attribute_x2f_converter: RTL and testbench
==========================================

// Module: attribute_x2f_converter
// PURPOSE
//  Converts fixed-point fragment attributes (depth Z, TMU0 texture S/T, RGBA color) back to IEEE-754 single floats.
//  Sits between the fixed-point pixel pipeline and the float-domain consumers: per-fragment attribute readback and the float blend/fog path.
//  AXI-stream in/out with full valid/ready backpressure; 3-stage pipeline (LZC -> normalize/round -> pack).
// PARAMETERS
//  INDEX_WIDTH       32  framebuffer index width (passthrough)
//  SCREEN_POS_WIDTH  11  screen x/y width (passthrough)
//  SUB_PIXEL_WIDTH   8   color channel width, Qn unsigned, all-ones = 1.0
//  DEPTH_WIDTH       16  fractional bits of unsigned depth input
//  TEX_FRAC_BITS     15  fractional bits of signed texture coords (S16.15)
// PORTS
//  aclk                       in   1    clock; all logic on rising edge
//  reset                      in   1    synchronous, active-high
//  s_xtf_tvalid               in   1    input fragment valid
//  s_xtf_tready               out  1    input accepted when tvalid & tready
//  s_xtf_tlast                in   1    last fragment of primitive (passthrough)
//  s_xtf_tspx / s_xtf_tspy    in   SCREEN_POS_WIDTH each  screen pos (passthrough)
//  s_xtf_tindex               in   INDEX_WIDTH   framebuffer index (passthrough)
//  s_xtf_tdepth_z             in   32   unsigned, DEPTH_WIDTH frac bits
//  s_xtf_ttexture0_s / _t     in   32 each  signed two's complement, TEX_FRAC_BITS frac bits
//  s_xtf_tcolor_r/_g/_b/_a    in   SUB_PIXEL_WIDTH each  Qn color
//  m_xtf_tvalid               out  1    output valid
//  m_xtf_tready               in   1    downstream ready
//  m_xtf_tlast, _tspx, _tspy, _tindex  out  as input  delayed passthrough
//  m_xtf_tdepth_z             out  32   float
//  m_xtf_ttexture0_s / _t     out  32 each  float
//  m_xtf_tcolor_r/_g/_b/_a    out  32 each  float
// BEHAVIOUR
//  - Pipeline enable ce = !m_xtf_tvalid | m_xtf_tready; all 3 stages (data+valid) advance together on ce.
//  - s_xtf_tready = ce & !reset. Bubbles are not collapsed. Latency exactly 3 cycles with m_xtf_tready held high.
//  - Holding: while m_xtf_tvalid & !m_xtf_tready all outputs are stable; no fragment dropped or duplicated; order preserved.
//  - Reset: all stage valids and m_xtf_tvalid = 0; all m_ data/sideband outputs = 0; s_xtf_tready = 0 while reset high.
//    Reset mid-stream discards every in-flight fragment; first accept possible on the first cycle after reset falls.
//  - Per-channel conversion (value v, F frac bits, signed flag):
//    stage 1: sign = signed ? v[31] : 0; mag = sign ? -v : v (33-bit internally so v = 0x80000000 -> mag = 2^31); lz = LZC(mag).
//    stage 2: norm = mag << lz (MSB at bit 31); exp = 127 + 31 - lz - F; mantissa = norm[30:8], guard/sticky from norm[7:0].
//    stage 3: pack {sign, exp[7:0], mantissa}. mag == 0 -> +0.0 (0x00000000); never -0.0.
//  - Exponent range: every legal input yields 1 <= exp <= 254 for the given widths; no denormals/inf/NaN are produced.
//  - Depth: unsigned, F = DEPTH_WIDTH. Texture S/T: signed, F = TEX_FRAC_BITS.
//  - Color: unsigned, F = SUB_PIXEL_WIDTH (input zero-extended to 32 bits), except input == all-ones -> exactly 1.0 (0x3F800000).
//    Inverts the float->fixed clamp, so [0,1] round-trips.
//  - Sideband (tlast, tspx, tspy, tindex) is delayed through the same 3 enabled stages.
// CONFIGURATION
//  ATTRIB_X2F_ROUND_EN defined:
//    round-to-nearest-even on the bits below the mantissa (norm[7:0]).
//    Mantissa carry-out sets mantissa = 0 and exp = exp + 1.
//    Latency unchanged.
//  ATTRIB_X2F_ROUND_EN undefined: truncate toward zero; no rounding adder synthesized.
// TESTING
//  1. texture0_s = 0x00008000 (+1.0), texture0_t = 0xFFFEC000 (-2.5) -> 0x3F800000 / 0xC0200000, 3 cycles after accept.
//  2. depth_z = 0x00008000 -> 0x3F000000; depth_z = 0 -> 0x00000000; texture = 0x80000000 -> 0xC7800000 (-65536.0).
//  3. color r/g/b/a = 0xFF/0x80/0x00/0x01 -> 0x3F800000 / 0x3F000000 / 0x00000000 / 0x3B800000.
//  4. texture0_s = 0x7FFFFFFF: without ROUND_EN -> 0x477FFFFF; with ROUND_EN -> 0x47800000.
//  5. Stream 6 fragments, drop m_xtf_tready for 4 cycles mid-stream:
//     s_xtf_tready falls the same cycle; outputs stay stable; all 6 arrive in order with correct tlast/tindex.
//  6. Pulse reset with 2 fragments in flight -> m_xtf_tvalid = 0 and outputs = 0 next cycle.
//     Neither in-flight fragment appears; a new fragment after reset emerges with latency 3.

Source files
------------

// File: rtl/attribute_x2f_converter_if.sv
// AXI-stream fragment bus for the fixed->float attribute converter.
// COLOR_WIDTH is SUB_PIXEL_WIDTH on the input side and 32 (float) on the output side.
interface attribute_x2f_converter_if #(
   parameter int INDEX_WIDTH      = 32,
   parameter int SCREEN_POS_WIDTH = 11,
   parameter int COLOR_WIDTH      = 8
);
   logic                        tvalid;
   logic                        tready;
   logic                        tlast;
   logic [SCREEN_POS_WIDTH-1:0] tspx;
   logic [SCREEN_POS_WIDTH-1:0] tspy;
   logic [INDEX_WIDTH-1:0]      tindex;
   logic [31:0]                 tdepth_z;
   logic [31:0]                 ttexture0_s;
   logic [31:0]                 ttexture0_t;
   logic [COLOR_WIDTH-1:0]      tcolor_r;
   logic [COLOR_WIDTH-1:0]      tcolor_g;
   logic [COLOR_WIDTH-1:0]      tcolor_b;
   logic [COLOR_WIDTH-1:0]      tcolor_a;

   modport master (
      output tvalid, tlast, tspx, tspy, tindex, tdepth_z, ttexture0_s, ttexture0_t,
             tcolor_r, tcolor_g, tcolor_b, tcolor_a,
      input  tready
   );

   modport slave (
      input  tvalid, tlast, tspx, tspy, tindex, tdepth_z, ttexture0_s, ttexture0_t,
             tcolor_r, tcolor_g, tcolor_b, tcolor_a,
      output tready
   );
endinterface

// File: rtl/attribute_x2f_converter.sv
// Fixed-point fragment attributes -> IEEE-754 singles, 3-stage LZC/normalize/pack pipeline.
// Define ATTRIB_X2F_ROUND_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module attribute_x2f_lane #(
   parameter int FRAC     = 16,
   parameter bit SIGNED   = 1'b0,
   parameter bit IS_COLOR = 1'b0,
   parameter int COLOR_W  = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ce,
   input  logic [31:0] v,
   output logic [31:0] f
);
   localparam logic [31:0] ONES  = (32'd1 << COLOR_W) - 32'd1;
   localparam logic [7:0]  EBASE = 8'(158 - FRAC);

   function automatic logic [5:0] lzc(input logic [31:0] x);
      lzc = 6'd32;
      for (int i = 0; i < 32; i++)
         if (x[i]) lzc = 6'(31 - i);
   endfunction

   logic        sign_n;
   logic [31:0] mag_n;
   logic        s1_sign, s1_one;
   logic [31:0] s1_mag;
   logic [5:0]  s1_lz;
   logic [7:0]  exp_n, exp_r;
   logic [22:0] mant_n;
   logic        s2_sign, s2_one, s2_zero;
   logic [7:0]  s2_exp;
   logic [22:0] s2_mant;

   // 32-bit negate of 0x80000000 yields 0x80000000, read unsigned as 2^31
   always_comb begin
      sign_n = SIGNED ? v[31] : 1'b0;
      mag_n  = sign_n ? (~v + 32'd1) : v;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_sign <= 1'b0;
         s1_one  <= 1'b0;
         s1_mag  <= '0;
         s1_lz   <= '0;
      end else if (ce) begin
         s1_sign <= sign_n;
         s1_one  <= IS_COLOR && (v == ONES);
         s1_mag  <= mag_n;
         s1_lz   <= lzc(mag_n);
      end
   end

`ifdef ATTRIB_X2F_ROUND_EN
   logic [31:0] norm;
   logic        rnd;
   logic [23:0] mant_sum;

   always_comb begin
      norm     = s1_mag << s1_lz;
      exp_n    = EBASE - {2'b00, s1_lz};
      rnd      = norm[7] & ((|norm[6:0]) | norm[8]);
      mant_sum = {1'b0, norm[30:8]} + {23'd0, rnd};
      mant_n   = mant_sum[22:0];
      exp_r    = exp_n + {7'd0, mant_sum[23]};
   end
`else
   logic [31:8] norm;

   always_comb begin
      norm   = 24'((s1_mag << s1_lz) >> 8);
      exp_n  = EBASE - {2'b00, s1_lz};
      mant_n = norm[30:8];
      exp_r  = exp_n;
   end
`endif

   // norm[31] is set exactly when the magnitude is non-zero
   always_ff @(posedge clk) begin
      if (reset) begin
         s2_sign <= 1'b0;
         s2_one  <= 1'b0;
         s2_zero <= 1'b0;
         s2_exp  <= '0;
         s2_mant <= '0;
      end else if (ce) begin
         s2_sign <= s1_sign;
         s2_one  <= s1_one;
         s2_zero <= !norm[31];
         s2_exp  <= exp_r;
         s2_mant <= mant_n;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         f <= '0;
      else if (ce)
         f <= s2_zero ? 32'h0000_0000 :
              s2_one  ? 32'h3F80_0000 : {s2_sign, s2_exp, s2_mant};
   end
endmodule

module attribute_x2f_converter #(
   parameter int INDEX_WIDTH      = 32,
   parameter int SCREEN_POS_WIDTH = 11,
   parameter int SUB_PIXEL_WIDTH  = 8,
   parameter int DEPTH_WIDTH      = 16,
   parameter int TEX_FRAC_BITS    = 15
) (
   input logic aclk,
   input logic reset,
   attribute_x2f_converter_if.slave  s_xtf,
   attribute_x2f_converter_if.master m_xtf
);
   localparam int NUM_LANES = 7;
   localparam int STAGES    = 3;

   typedef struct packed {
      logic                        tlast;
      logic [SCREEN_POS_WIDTH-1:0] spx;
      logic [SCREEN_POS_WIDTH-1:0] spy;
      logic [INDEX_WIDTH-1:0]      index;
   } sb_t;

   logic                            ce;
   logic [STAGES:1]                 vld_pipe;
   sb_t                             sb_in;
   sb_t [STAGES:1]                  sb_pipe;
   logic [NUM_LANES-1:0][31:0]      lane_in, lane_out;

   // Stalls only when the output holds a fragment nobody takes; bubbles are kept
   assign ce           = !vld_pipe[STAGES] | m_xtf.tready;
   assign s_xtf.tready = ce & !reset;

   always_comb begin
      sb_in       = '{tlast: s_xtf.tlast, spx: s_xtf.tspx, spy: s_xtf.tspy, index: s_xtf.tindex};
      lane_in[0]  = s_xtf.tdepth_z;
      lane_in[1]  = s_xtf.ttexture0_s;
      lane_in[2]  = s_xtf.ttexture0_t;
      lane_in[3]  = 32'(s_xtf.tcolor_r);
      lane_in[4]  = 32'(s_xtf.tcolor_g);
      lane_in[5]  = 32'(s_xtf.tcolor_b);
      lane_in[6]  = 32'(s_xtf.tcolor_a);
   end

   always_ff @(posedge aclk) begin
      if (reset) begin
         vld_pipe <= '0;
         sb_pipe  <= '0;
      end else if (ce) begin
         vld_pipe <= {vld_pipe[STAGES-1:1], s_xtf.tvalid};
         sb_pipe  <= {sb_pipe[STAGES-1:1], sb_in};
      end
   end

   // lane 0: depth, 1-2: texture S/T (signed), 3-6: RGBA
   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      attribute_x2f_lane #(
         .FRAC     (i == 0 ? DEPTH_WIDTH : (i < 3 ? TEX_FRAC_BITS : SUB_PIXEL_WIDTH)),
         .SIGNED   (i == 1 || i == 2),
         .IS_COLOR (i >= 3),
         .COLOR_W  (SUB_PIXEL_WIDTH)
      ) u_lane (
         .clk   (aclk),
         .reset (reset),
         .ce    (ce),
         .v     (lane_in[i]),
         .f     (lane_out[i])
      );
   end

   assign m_xtf.tvalid      = vld_pipe[STAGES];
   assign m_xtf.tlast       = sb_pipe[STAGES].tlast;
   assign m_xtf.tspx        = sb_pipe[STAGES].spx;
   assign m_xtf.tspy        = sb_pipe[STAGES].spy;
   assign m_xtf.tindex      = sb_pipe[STAGES].index;
   assign m_xtf.tdepth_z    = lane_out[0];
   assign m_xtf.ttexture0_s = lane_out[1];
   assign m_xtf.ttexture0_t = lane_out[2];
   assign m_xtf.tcolor_r    = lane_out[3];
   assign m_xtf.tcolor_g    = lane_out[4];
   assign m_xtf.tcolor_b    = lane_out[5];
   assign m_xtf.tcolor_a    = lane_out[6];
endmodule

// File: tb/tb_attribute_x2f_converter.sv
// Directed bench for attribute_x2f_converter: conversions, latency, backpressure, reset flush.
module tb_attribute_x2f_converter;
   logic aclk = 1'b0;
   logic reset;
   always #5 aclk = ~aclk;

   attribute_x2f_converter_if #(.INDEX_WIDTH(32), .SCREEN_POS_WIDTH(11), .COLOR_WIDTH(8))  s_xtf();
   attribute_x2f_converter_if #(.INDEX_WIDTH(32), .SCREEN_POS_WIDTH(11), .COLOR_WIDTH(32)) m_xtf();

   attribute_x2f_converter #(
      .INDEX_WIDTH(32), .SCREEN_POS_WIDTH(11), .SUB_PIXEL_WIDTH(8),
      .DEPTH_WIDTH(16), .TEX_FRAC_BITS(15)
   ) dut (
      .aclk  (aclk),
      .reset (reset),
      .s_xtf (s_xtf),
      .m_xtf (m_xtf)
   );

`ifdef ATTRIB_X2F_ROUND_EN
   localparam logic [31:0] NEAR_MAX = 32'h4780_0000;
`else
   localparam logic [31:0] NEAR_MAX = 32'h477F_FFFF;
`endif

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [31:0] idx, d, ts, tt, input logic [7:0] r, g, b, a);
      s_xtf.tindex      = idx;
      s_xtf.tlast       = idx[0];
      s_xtf.tspx        = 11'(idx + 32'd3);
      s_xtf.tspy        = 11'(idx + 32'd5);
      s_xtf.tdepth_z    = d;
      s_xtf.ttexture0_s = ts;
      s_xtf.ttexture0_t = tt;
      s_xtf.tcolor_r    = r;
      s_xtf.tcolor_g    = g;
      s_xtf.tcolor_b    = b;
      s_xtf.tcolor_a    = a;
   endtask

   // single fragment through an idle pipe, checked at exactly 3 cycles
   task automatic xfer(input logic [31:0] idx, d, ts, tt, input logic [7:0] r, g, b, a,
                       input logic [31:0] ed, es, et, er, eg, eb, ea);
      logic [10:0] px, py;
      px = 11'(idx + 32'd3);
      py = 11'(idx + 32'd5);
      @(negedge aclk);
      drive(idx, d, ts, tt, r, g, b, a);
      s_xtf.tvalid = 1'b1;
      chk("acc_rdy", 32'(s_xtf.tready), 32'd1);
      @(posedge aclk); #1 s_xtf.tvalid = 1'b0;
      @(negedge aclk);
      @(negedge aclk);
      chk("lat_early", 32'(m_xtf.tvalid), 32'd0);
      @(negedge aclk);
      chk("lat_valid", 32'(m_xtf.tvalid), 32'd1);
      chk("depth",     m_xtf.tdepth_z, ed);
      chk("tex_s",     m_xtf.ttexture0_s, es);
      chk("tex_t",     m_xtf.ttexture0_t, et);
      chk("col_r",     m_xtf.tcolor_r, er);
      chk("col_g",     m_xtf.tcolor_g, eg);
      chk("col_b",     m_xtf.tcolor_b, eb);
      chk("col_a",     m_xtf.tcolor_a, ea);
      chk("index",     m_xtf.tindex, idx);
      chk("tlast",     32'(m_xtf.tlast), 32'(idx[0]));
      chk("spx",       32'(m_xtf.tspx), 32'(px));
      chk("spy",       32'(m_xtf.tspy), 32'(py));
   endtask

   logic [31:0] stream_exp [6] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
                                   32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000};

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rx, ghosts;
      logic drv_ok;
      reset = 1'b1;
      s_xtf.tvalid = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      m_xtf.tready = 1'b1;
      repeat (3) @(posedge aclk);
      #1;
      chk("rst_mvalid", 32'(m_xtf.tvalid), 32'd0);
      chk("rst_sready", 32'(s_xtf.tready), 32'd0);
      chk("rst_depth",  m_xtf.tdepth_z, 32'd0);
      chk("rst_col_a",  m_xtf.tcolor_a, 32'd0);
      chk("rst_index",  m_xtf.tindex, 32'd0);
      @(negedge aclk) reset = 1'b0;

      // +1.0 / -2.5 texture
      xfer(1, 32'h0, 32'h0000_8000, 32'hFFFE_C000, 8'h00, 8'h00, 8'h00, 8'h00,
           32'h0, 32'h3F80_0000, 32'hC020_0000, 32'h0, 32'h0, 32'h0, 32'h0);
      // depth 0.5, most negative texture
      xfer(2, 32'h0000_8000, 32'h8000_0000, 32'h8000_0000, 8'h00, 8'h00, 8'h00, 8'h00,
           32'h3F00_0000, 32'hC780_0000, 32'hC780_0000, 32'h0, 32'h0, 32'h0, 32'h0);
      // colors incl. all-ones -> 1.0 and 1 LSB
      xfer(3, 32'h0, 32'h0, 32'h0, 8'hFF, 8'h80, 8'h00, 8'h01,
           32'h0, 32'h0, 32'h0, 32'h3F80_0000, 32'h3F00_0000, 32'h0, 32'h3B80_0000);
      // largest magnitudes exercise truncation vs rounding carry
      xfer(4, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_8000, 8'hC0, 8'h00, 8'h00, 8'hFE,
           NEAR_MAX, NEAR_MAX, 32'hBF80_0000, 32'h3F40_0000, 32'h0, 32'h0, 32'h3F7E_0000);

      // 6-fragment stream with a 4-cycle output stall
      rx = 0;
      drv_ok = 1'b1;
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               logic acc;
               @(negedge aclk);
               drive(32'(i + 10), 32'h0, 32'(i + 1) << 15, 32'h0, 8'h00, 8'h00, 8'h00, 8'h00);
               s_xtf.tlast  = (i == 5);
               s_xtf.tvalid = 1'b1;
               acc = 1'b0;
               for (int w = 0; w < 50; w++) begin
                  acc = s_xtf.tready;
                  @(posedge aclk);
                  if (acc) break;
                  @(negedge aclk);
               end
               if (!acc) drv_ok = 1'b0;
            end
            @(negedge aclk) s_xtf.tvalid = 1'b0;
         end
         begin
            logic        prev_stall;
            logic [31:0] prev_idx, prev_ts;
            prev_stall = 1'b0;
            prev_idx   = '0;
            prev_ts    = '0;
            for (int c = 0; c < 100 && rx < 6; c++) begin
               @(negedge aclk);
               if (m_xtf.tvalid && !m_xtf.tready) begin
                  chk("stall_sready", 32'(s_xtf.tready), 32'd0);
                  if (prev_stall) begin
                     chk("stall_idx", m_xtf.tindex, prev_idx);
                     chk("stall_ts",  m_xtf.ttexture0_s, prev_ts);
                  end
                  prev_stall = 1'b1;
                  prev_idx   = m_xtf.tindex;
                  prev_ts    = m_xtf.ttexture0_s;
               end else begin
                  prev_stall = 1'b0;
               end
               if (m_xtf.tvalid && m_xtf.tready) begin
                  chk("strm_idx",  m_xtf.tindex, 32'(rx + 10));
                  chk("strm_ts",   m_xtf.ttexture0_s, stream_exp[rx]);
                  chk("strm_last", 32'(m_xtf.tlast), 32'(rx == 5));
                  rx++;
               end
            end
         end
         begin
            repeat (4) @(posedge aclk);
            #1 m_xtf.tready = 1'b0;
            repeat (4) @(posedge aclk);
            #1 m_xtf.tready = 1'b1;
         end
      join
      chk("strm_count", 32'(rx), 32'd6);
      chk("strm_drv",   32'(drv_ok), 32'd1);
      repeat (4) @(posedge aclk);

      // reset with two fragments in flight
      @(negedge aclk);
      drive(20, 32'h0001_0000, 32'h0000_8000, 32'h0, 8'h10, 8'h00, 8'h00, 8'h00);
      s_xtf.tvalid = 1'b1;
      @(negedge aclk);
      drive(21, 32'h0002_0000, 32'h0001_0000, 32'h0, 8'h20, 8'h00, 8'h00, 8'h00);
      @(posedge aclk);
      #1 s_xtf.tvalid = 1'b0;
      reset = 1'b1;
      @(posedge aclk);
      #1;
      chk("rst2_mvalid", 32'(m_xtf.tvalid), 32'd0);
      chk("rst2_index",  m_xtf.tindex, 32'd0);
      chk("rst2_ts",     m_xtf.ttexture0_s, 32'd0);
      chk("rst2_sready", 32'(s_xtf.tready), 32'd0);
      @(negedge aclk) reset = 1'b0;
      #1 chk("rst2_rdy_after", 32'(s_xtf.tready), 32'd1);
      ghosts = 0;
      repeat (4) begin
         @(negedge aclk);
         if (m_xtf.tvalid) ghosts++;
      end
      chk("rst2_ghosts", 32'(ghosts), 32'd0);
      xfer(22, 32'h0000_4000, 32'hFFFF_8000, 32'h0000_8000, 8'h00, 8'hFF, 8'h00, 8'h00,
           32'h3E80_0000, 32'hBF80_0000, 32'h3F80_0000, 32'h0, 32'h3F80_0000, 32'h0, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
